mlp_load_sequencer: RTL and testbench
=====================================

MLP_LOAD_SEQUENCER -- requirements
Module: mlp_load_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_ROWS, 16: input rows per run.
- N_WEIGHTS, 8: weight words per layer.
- LAYER_GAP, 4: idle cycles after each layer's weights.
- N_RESULTS, 16: result words expected per run.
- RES_DEPTH, 16: result FIFO depth.
REQ-002 Ports (name, direction, width, meaning), one per line; clock is clk and reset is rst_n, synchronous, active-low:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- start_i, in, 1: run request pulse.
- num_layers_i, in, 3: layer count minus 1.
- busy_o, out, 1: run in progress.
- done_o, out, 1: one-cycle run-complete pulse.
- overflow_o, out, 1: sticky result-drop flag.
- src_valid_i, in, 1: source word valid.
- src_ready_o, out, 1: sequencer accepts word.
- src_data_i, in, 32: source word.
- load_en_o, out, 1: accelerator load strobe.
- load_payload_o, out, 32: load data.
- load_type_o, out, 1: 1 = input, 0 = weight.
- input_load_number_o, out, 4: input row 0-15.
- layer_number_o, out, 3: layer 0-7.
- weight_number_o, out, 3: weight index 0-7.
- result_valid_i, in, 1: accelerator result strobe.
- result_payload_i, in, 32: accelerator result.
- res_valid_o, out, 1: FIFO head valid.
- res_ready_i, in, 1: consumer pop.
- res_data_o, out, 32: FIFO head.

Function
REQ-003 FSM states: IDLE, LOAD_IN, LOAD_W, GAP, WAIT_RES, DONE.
REQ-004 IDLE: start_i=1 latches num_layers_i and goes to LOAD_IN; all counters clear.
REQ-005 start_i outside IDLE is ignored.
REQ-006 src_ready_o=1 only in LOAD_IN and LOAD_W; a word transfers on src_valid_i & src_ready_o.
REQ-007 A transfer in cycle t produces load_en_o=1 in cycle t+1, with load_payload_o=src_data_i and the indices registered from cycle t; otherwise load_en_o=0 and the other load outputs hold their values.
REQ-008 LOAD_IN: load_type_o=1; input_load_number_o=row counter 0..N_ROWS-1; after transfer of row N_ROWS-1, go to LOAD_W with layer=0.
REQ-009 LOAD_W: load_type_o=0; weight_number_o=0..N_WEIGHTS-1; layer_number_o=current layer; after transfer of weight N_WEIGHTS-1, go to GAP.
REQ-010 GAP lasts exactly LAYER_GAP cycles. It then goes to LOAD_W with layer+1 if layer < latched count, else to WAIT_RES.
REQ-011 WAIT_RES counts result_valid_i pulses; after the N_RESULTS-th pulse, go to DONE.
REQ-012 result_valid_i outside WAIT_RES is ignored (not stored, not counted).
REQ-013 In WAIT_RES, a result is pushed to the FIFO if it is not full. If the FIFO is full, the result is dropped, still counted, and overflow_o is set.
REQ-014 If a pop and a result arrive in the same cycle on a full FIFO, the push succeeds (pop frees the slot).
REQ-015 DONE lasts one cycle: done_o=1, then IDLE.
REQ-016 busy_o=1 in all states except IDLE.
REQ-017 overflow_o clears only on reset or on a start accepted in IDLE.
REQ-018 FIFO behaviour: first-word-fall-through; res_valid_o = not empty; pop on res_valid_o & res_ready_i; pointers wrap modulo RES_DEPTH; the FIFO is drained independently of FSM state.
REQ-019 Stalls: src_valid_i=0 stalls LOAD_IN/LOAD_W indefinitely with counters held; there is no timeout.

Reset
REQ-020 rst_n=0 at a clock edge forces IDLE and clears all counters, FIFO pointers and the latched layer count.
REQ-021 Reset values: busy_o=0, done_o=0, overflow_o=0, src_ready_o=0, load_en_o=0, load_payload_o=0, load_type_o=0, all index outputs 0, res_valid_o=0, res_data_o don't-care.
REQ-022 Reset mid-run abandons the run; no done_o pulse is produced.

Structure
REQ-023 Package mlp_acc_pkg holds the FSM state enum, the LOAD_TYPE_INPUT/LOAD_TYPE_WEIGHT constants and the default parameter values.
REQ-024 The result FIFO is sub-module mlp_result_fifo (parameters: width 32, depth RES_DEPTH; outputs full and empty).

Verification
REQ-025 The bench shall cover these directed scenarios:
- Full run: start, num_layers_i=1, src always valid, 16 results -> 16 input loads (rows 0..15, type 1), then 8 loads at layer 0, 4 idle cycles, 8 loads at layer 1, one done_o pulse after the 16th result; payload order matches the source.
- Backpressure: src_valid_i toggled randomly -> identical load sequence, no skipped or duplicated index.
- Overflow: res_ready_i=0, 17 results with N_RESULTS=17 -> 16 stored, overflow_o=1, done_o pulses; the next start clears overflow_o.
- Full-boundary: FIFO full, simultaneous pop and push -> push accepted, count stays 16.
- Reset mid-operation: rst_n=0 during LOAD_W layer 2 -> next cycle busy_o=0, load_en_o=0, FIFO empty; a new run starts at row 0.
- Start while busy: start_i pulsed during GAP -> ignored; run completes normally.

Source files
------------

// File: rtl/mlp_acc_pkg.sv
// Shared state encoding, load-type constants and default sizing for the
// MLP accelerator load sequencer.
package mlp_acc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoadIn,
        StLoadW,
        StGap,
        StWaitRes,
        StDone
    } seq_state_e;

    localparam logic LOAD_TYPE_INPUT  = 1'b1;
    localparam logic LOAD_TYPE_WEIGHT = 1'b0;

    localparam int unsigned DEF_N_ROWS    = 16;
    localparam int unsigned DEF_N_WEIGHTS = 8;
    localparam int unsigned DEF_LAYER_GAP = 4;
    localparam int unsigned DEF_N_RESULTS = 16;
    localparam int unsigned DEF_RES_DEPTH = 16;

endpackage

// File: rtl/mlp_result_fifo.sv
// First-word-fall-through result FIFO; a pop in the same cycle frees a slot
// for a push even when the FIFO is full.
module mlp_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = mlp_acc_pkg::DEF_RES_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until a push has landed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Streams input rows and per-layer weights from a source into the accelerator
// load port, then collects a fixed number of results into a FIFO.
module mlp_load_sequencer
    import mlp_acc_pkg::*;
#(
    parameter int unsigned N_ROWS    = DEF_N_ROWS,
    parameter int unsigned N_WEIGHTS = DEF_N_WEIGHTS,
    parameter int unsigned LAYER_GAP = DEF_LAYER_GAP,
    parameter int unsigned N_RESULTS = DEF_N_RESULTS,
    parameter int unsigned RES_DEPTH = DEF_RES_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  num_layers_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o,
    input  logic        src_valid_i,
    output logic        src_ready_o,
    input  logic [31:0] src_data_i,
    output logic        load_en_o,
    output logic [31:0] load_payload_o,
    output logic        load_type_o,
    output logic [3:0]  input_load_number_o,
    output logic [2:0]  layer_number_o,
    output logic [2:0]  weight_number_o,
    input  logic        result_valid_i,
    input  logic [31:0] result_payload_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o
);

    localparam int unsigned GAP_W = (LAYER_GAP > 1) ? $clog2(LAYER_GAP) : 1;
    localparam int unsigned RES_W = (N_RESULTS > 1) ? $clog2(N_RESULTS) : 1;

    seq_state_e       state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [2:0]       weight_q, weight_d;
    logic [2:0]       layer_q, layer_d;
    logic [2:0]       num_layers_q, num_layers_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [RES_W-1:0] res_cnt_q, res_cnt_d;
    logic             overflow_q, overflow_d;
    logic             load_en_q, load_en_d;
    logic [31:0]      load_payload_q, load_payload_d;
    logic             load_type_q, load_type_d;
    logic [3:0]       in_num_q, in_num_d;
    logic [2:0]       layer_out_q, layer_out_d;
    logic [2:0]       weight_out_q, weight_out_d;

    logic xfer, res_accept, res_drop;
    logic fifo_full, fifo_empty, fifo_pop;

    assign src_ready_o = (state_q == StLoadIn) || (state_q == StLoadW);
    assign xfer        = src_valid_i & src_ready_o;
    assign res_accept  = (state_q == StWaitRes) & result_valid_i;
    assign fifo_pop    = ~fifo_empty & res_ready_i;
    assign res_drop    = res_accept & fifo_full & ~fifo_pop;

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        weight_d       = weight_q;
        layer_d        = layer_q;
        num_layers_d   = num_layers_q;
        gap_d          = gap_q;
        res_cnt_d      = res_cnt_q;
        overflow_d     = overflow_q;
        load_en_d      = 1'b0;
        load_payload_d = load_payload_q;
        load_type_d    = load_type_q;
        in_num_d       = in_num_q;
        layer_out_d    = layer_out_q;
        weight_out_d   = weight_out_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d      = StLoadIn;
                    num_layers_d = num_layers_i;
                    row_d        = '0;
                    weight_d     = '0;
                    layer_d      = '0;
                    gap_d        = '0;
                    res_cnt_d    = '0;
                    overflow_d   = 1'b0;
                end
            end
            StLoadIn: begin
                if (xfer) begin
                    load_en_d      = 1'b1;
                    load_payload_d = src_data_i;
                    load_type_d    = LOAD_TYPE_INPUT;
                    in_num_d       = row_q;
                    if (row_q == 4'(N_ROWS - 1)) begin
                        state_d  = StLoadW;
                        row_d    = '0;
                        layer_d  = '0;
                        weight_d = '0;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StLoadW: begin
                if (xfer) begin
                    load_en_d      = 1'b1;
                    load_payload_d = src_data_i;
                    load_type_d    = LOAD_TYPE_WEIGHT;
                    layer_out_d    = layer_q;
                    weight_out_d   = weight_q;
                    if (weight_q == 3'(N_WEIGHTS - 1)) begin
                        state_d  = StGap;
                        weight_d = '0;
                        gap_d    = '0;
                    end else begin
                        weight_d = weight_q + 1'b1;
                    end
                end
            end
            StGap: begin
                if (gap_q == GAP_W'(LAYER_GAP - 1)) begin
                    gap_d = '0;
                    if (layer_q < num_layers_q) begin
                        state_d = StLoadW;
                        layer_d = layer_q + 1'b1;
                    end else begin
                        state_d = StWaitRes;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StWaitRes: begin
                // Dropped results still count towards completion.
                if (result_valid_i) begin
                    if (res_drop) overflow_d = 1'b1;
                    if (res_cnt_q == RES_W'(N_RESULTS - 1)) begin
                        state_d   = StDone;
                        res_cnt_d = '0;
                    end else begin
                        res_cnt_d = res_cnt_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            row_q          <= '0;
            weight_q       <= '0;
            layer_q        <= '0;
            num_layers_q   <= '0;
            gap_q          <= '0;
            res_cnt_q      <= '0;
            overflow_q     <= 1'b0;
            load_en_q      <= 1'b0;
            load_payload_q <= '0;
            load_type_q    <= 1'b0;
            in_num_q       <= '0;
            layer_out_q    <= '0;
            weight_out_q   <= '0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            weight_q       <= weight_d;
            layer_q        <= layer_d;
            num_layers_q   <= num_layers_d;
            gap_q          <= gap_d;
            res_cnt_q      <= res_cnt_d;
            overflow_q     <= overflow_d;
            load_en_q      <= load_en_d;
            load_payload_q <= load_payload_d;
            load_type_q    <= load_type_d;
            in_num_q       <= in_num_d;
            layer_out_q    <= layer_out_d;
            weight_out_q   <= weight_out_d;
        end
    end

    assign busy_o              = (state_q != StIdle);
    assign done_o              = (state_q == StDone);
    assign overflow_o          = overflow_q;
    assign load_en_o           = load_en_q;
    assign load_payload_o      = load_payload_q;
    assign load_type_o         = load_type_q;
    assign input_load_number_o = in_num_q;
    assign layer_number_o      = layer_out_q;
    assign weight_number_o     = weight_out_q;
    assign res_valid_o         = ~fifo_empty;

    mlp_result_fifo #(
        .WIDTH (32),
        .DEPTH (RES_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (res_accept),
        .wdata_i (result_payload_i),
        .pop_i   (fifo_pop),
        .rdata_o (res_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Scoreboard bench: two sequencer instances (16 and 17 results per run) share
// stimulus; only the selected one is ever started.
module tb_mlp_load_sequencer;
    import mlp_acc_pkg::*;

    localparam int N_ROWS    = 16;
    localparam int N_WEIGHTS = 8;
    localparam int LAYER_GAP = 4;
    localparam int RES_DEPTH = 16;

    typedef struct packed {
        logic        typ;
        logic [3:0]  row;
        logic [2:0]  layer;
        logic [2:0]  weight;
        logic [31:0] data;
    } load_t;

    logic        clk, rst_n, start_r, sel;
    logic [2:0]  num_layers_i;
    logic        src_valid_i, result_valid_i, res_ready_i;
    logic [31:0] src_data_i, result_payload_i;
    logic [1:0]  start_w, busy_w, done_w, ovf_w, srdy_w, len_w, type_w, resv_w;
    logic [1:0][31:0] payload_w, res_data_w;
    logic [1:0][3:0]  row_w;
    logic [1:0][2:0]  layer_w, weight_w;

    int n_tests = 0, n_fail = 0;
    int cycle = 0, last_wload = 0, pop_cnt = 0, done_cnt = 0, runs_done = 0;
    int rdy_mode = 0, res_left = 0;
    bit res_noise = 0, chk_gap = 0;
    logic       exp_ovf [2];
    logic [3:0] h_row [2];
    logic [2:0] h_layer [2];
    logic [2:0] h_weight [2];
    load_t       exp_load_q[$];
    logic [31:0] exp_res_q[$];

    assign start_w = sel ? {start_r, 1'b0} : {1'b0, start_r};

    mlp_load_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_w[0]), .num_layers_i(num_layers_i),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .overflow_o(ovf_w[0]),
        .src_valid_i(src_valid_i), .src_ready_o(srdy_w[0]), .src_data_i(src_data_i),
        .load_en_o(len_w[0]), .load_payload_o(payload_w[0]), .load_type_o(type_w[0]),
        .input_load_number_o(row_w[0]), .layer_number_o(layer_w[0]),
        .weight_number_o(weight_w[0]), .result_valid_i(result_valid_i),
        .result_payload_i(result_payload_i), .res_valid_o(resv_w[0]),
        .res_ready_i(res_ready_i), .res_data_o(res_data_w[0])
    );

    mlp_load_sequencer #(.N_RESULTS(17)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_w[1]), .num_layers_i(num_layers_i),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .overflow_o(ovf_w[1]),
        .src_valid_i(src_valid_i), .src_ready_o(srdy_w[1]), .src_data_i(src_data_i),
        .load_en_o(len_w[1]), .load_payload_o(payload_w[1]), .load_type_o(type_w[1]),
        .input_load_number_o(row_w[1]), .layer_number_o(layer_w[1]),
        .weight_number_o(weight_w[1]), .result_valid_i(result_valid_i),
        .result_payload_i(result_payload_i), .res_valid_o(resv_w[1]),
        .res_ready_i(res_ready_i), .res_data_o(res_data_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every load strobe and every FIFO pop is matched against the scoreboard.
    initial begin
        load_t got, e;
        forever begin
            @(negedge clk);
            cycle++;
            if (len_w[sel] === 1'b1) begin
                got = {type_w[sel], row_w[sel], layer_w[sel], weight_w[sel], payload_w[sel]};
                if (exp_load_q.size() == 0) begin
                    check("load_unexpected", 64'(got), 64'(0));
                end else begin
                    e = exp_load_q.pop_front();
                    check("load", 64'(got), 64'(e));
                    if (chk_gap && e.typ == LOAD_TYPE_WEIGHT && e.weight == 0 && e.layer != 0)
                        check("gap_len", 64'(cycle - last_wload), 64'(LAYER_GAP + 1));
                    if (e.typ == LOAD_TYPE_WEIGHT) last_wload = cycle;
                end
            end
            if (resv_w[sel] === 1'b1 && res_ready_i === 1'b1) begin
                pop_cnt++;
                if (exp_res_q.size() == 0) check("res_unexpected", 64'(res_data_w[sel]), 64'(0));
                else check("res_data", 64'(res_data_w[sel]), 64'(exp_res_q.pop_front()));
            end
            if (done_w[sel] === 1'b1) done_cnt++;
        end
    end

    // Result producer and consumer; decides push/drop from the model FIFO occupancy.
    initial begin
        result_valid_i = 1'b0;
        result_payload_i = '0;
        res_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       res_ready_i = 1'b0;
                1:       res_ready_i = 1'b1;
                2:       res_ready_i = 1'($urandom_range(0, 1));
                default: res_ready_i = (exp_res_q.size() == RES_DEPTH);
            endcase
            result_valid_i = 1'b0;
            if (res_left > 0 && ($urandom_range(0, 2) != 0 ||
                                 (rdy_mode == 3 && exp_res_q.size() == RES_DEPTH))) begin
                result_valid_i = 1'b1;
                result_payload_i = $urandom;
                res_left--;
                if (exp_res_q.size() < RES_DEPTH || res_ready_i) exp_res_q.push_back(result_payload_i);
                else exp_ovf[sel] = 1'b1;
            end else if (res_noise && $urandom_range(0, 3) == 0) begin
                result_valid_i = 1'b1;
                result_payload_i = $urandom;
            end
        end
    end

    task automatic clear_model();
        exp_load_q.delete();
        exp_res_q.delete();
        rdy_mode = 0;
        res_left = 0;
        for (int s = 0; s < 2; s++) begin
            exp_ovf[s] = 1'b0;
            h_row[s] = '0;
            h_layer[s] = '0;
            h_weight[s] = '0;
        end
    endtask

    task automatic run(input logic which, input int layers, input bit bp, input bit gap_start,
                       input int nres, input int rmode, input bit drain, input int abort_k);
        int total = N_ROWS + (layers + 1) * N_WEIGHTS;
        int k = 0, j, guard = 0;
        bit pulsed = 0;
        sel = which;
        check("overflow_sticky", 64'(ovf_w[which]), 64'(exp_ovf[which]));
        @(posedge clk); #1;
        start_r = 1'b1;
        num_layers_i = 3'(layers);
        @(posedge clk); #1;
        start_r = 1'b0;
        num_layers_i = 3'($urandom);
        exp_ovf[which] = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy_w[which]), 64'(1));
        check("overflow_cleared", 64'(ovf_w[which]), 64'(0));
        res_noise = 1;
        chk_gap = !bp;
        pop_cnt = 0;
        while (k < total) begin
            @(posedge clk); #1;
            if (abort_k >= 0 && k == abort_k) begin
                src_valid_i = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                clear_model();
                res_noise = 0;
                @(negedge clk);
                check("rst_busy", 64'(busy_w[which]), 64'(0));
                check("rst_load_en", 64'(len_w[which]), 64'(0));
                check("rst_fifo_empty", 64'(resv_w[which]), 64'(0));
                check("rst_src_ready", 64'(srdy_w[which]), 64'(0));
                return;
            end
            start_r = gap_start && !pulsed && (k == N_ROWS + N_WEIGHTS);
            if (start_r) begin
                pulsed = 1;
                num_layers_i = 3'($urandom);
            end
            src_valid_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            src_data_i = $urandom;
            @(negedge clk);
            if (src_valid_i && srdy_w[which]) begin
                if (k < N_ROWS) begin
                    h_row[which] = 4'(k);
                    exp_load_q.push_back({LOAD_TYPE_INPUT, h_row[which], h_layer[which],
                                          h_weight[which], src_data_i});
                end else begin
                    j = k - N_ROWS;
                    h_layer[which] = 3'(j / N_WEIGHTS);
                    h_weight[which] = 3'(j % N_WEIGHTS);
                    exp_load_q.push_back({LOAD_TYPE_WEIGHT, h_row[which], h_layer[which],
                                          h_weight[which], src_data_i});
                end
                k++;
                guard = 0;
            end else if (++guard > 200) begin
                check("src_stall_timeout", 64'(k), 64'(total));
                break;
            end
        end
        @(posedge clk); #1;
        start_r = 1'b0;
        src_valid_i = 1'b0;
        @(negedge clk);
        res_noise = 0;
        guard = 0;
        while (exp_load_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("loads_all_seen", 64'(exp_load_q.size()), 64'(0));
        repeat (LAYER_GAP + 2) @(negedge clk);
        check("ready_low_in_wait", 64'(srdy_w[which]), 64'(0));
        rdy_mode = rmode;
        res_left = nres;
        guard = 0;
        while (res_left > 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("results_sent", 64'(res_left), 64'(0));
        @(negedge clk);
        check("done_pulse", 64'(done_w[which]), 64'(1));
        check("overflow_at_done", 64'(ovf_w[which]), 64'(exp_ovf[which]));
        runs_done++;
        @(negedge clk);
        check("done_one_cycle", 64'(done_w[which]), 64'(0));
        check("idle_after_done", 64'(busy_w[which]), 64'(0));
        if (drain) begin
            rdy_mode = 1;
            guard = 0;
            while (exp_res_q.size() != 0 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            repeat (2) @(negedge clk);
            check("fifo_empty_after_drain", 64'(resv_w[which]), 64'(0));
        end
        rdy_mode = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b0;
        start_r = 1'b0;
        num_layers_i = '0;
        src_valid_i = 1'b0;
        src_data_i = '0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({busy_w, done_w, ovf_w, srdy_w, len_w, type_w, row_w,
                                 layer_w, weight_w, resv_w}), 64'(0));
        check("reset_payload", 64'(payload_w), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Full run, source always valid, results left in the FIFO.
        run(1'b0, 1, 1'b0, 1'b0, 16, 0, 1'b0, -1);
        check("fifo_full_held", 64'(resv_w[0]), 64'(1));
        // Reset during layer 2 weights; FIFO still holds the previous results.
        run(1'b0, 3, 1'b1, 1'b0, 16, 0, 1'b0, N_ROWS + 2 * N_WEIGHTS + 3);
        // Backpressure, random consumer, start pulse during the gap.
        run(1'b0, 2, 1'b1, 1'b1, 16, 2, 1'b1, -1);
        // Overflow: consumer stalled, 17 results into 16 slots.
        run(1'b1, 0, 1'b0, 1'b0, 17, 0, 1'b1, -1);
        check("overflow_stored", 64'(pop_cnt), 64'(16));
        // Full-boundary: pop and push together on a full FIFO.
        run(1'b1, 0, 1'b1, 1'b0, 17, 3, 1'b1, -1);
        check("boundary_stored", 64'(pop_cnt), 64'(17));

        check("done_count", 64'(done_cnt), 64'(runs_done));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
